divisor_secuencial: RTL and testbench

DIVISOR_SECUENCIAL -- requirements
Module: divisor_secuencial

---
 rtl/divisor_secuencial.sv | 125 ++++++++++++
 tb/tb_divisor_secuencial.sv | 163 ++++++++++++++++
 2 files changed

// File: rtl/divisor_secuencial.sv
// rtl/divisor_secuencial.sv - restoring sequential divider, 2N-bit dividend by N-bit divisor
module divisor_secuencial #(
  parameter int N = 24
) (
  input  logic           clk,
  input  logic           reset,
  input  logic           start,
  input  logic [2*N-1:0] Dividendo,
  input  logic [N-1:0]   Divisor,
  output logic           ready,
  output logic           done,
  output logic [N-1:0]   Cociente,
  output logic [N-1:0]   Residuo,
  output logic           div_cero,
  output logic           desborde
);

  localparam int CW = (N > 1) ? $clog2(N) : 1;

  typedef enum logic [1:0] {IDLE, DIVIDE, DONE} estado_t;

  estado_t        estado, estado_sig;
  logic [2*N-1:0] dvd_q;
  logic [N-1:0]   dvs_q;
  logic           pendiente;
  logic [N:0]     resto;
  logic [N-1:0]   despl;
  logic [CW-1:0]  cnt;

  logic [N-1:0]   alto;
  logic           exc_cero, exc_desb;
  logic [N:0]     resto_sh, resta, resto_nuevo;
  logic           cabe;
  logic [N-1:0]   despl_nuevo;

  // Operands are registered first, the decision is taken one cycle later on the captured values
  assign alto     = dvd_q[2*N-1:N];
  assign exc_cero = (dvs_q == '0);
  assign exc_desb = !exc_cero && (alto >= dvs_q);

  // One restoring step at N+1 bits: the shifted remainder can exceed 2^N-1
  assign resto_sh    = {resto[N-1:0], despl[N-1]};
  assign cabe        = (resto_sh >= {1'b0, dvs_q});
  assign resta       = resto_sh - {1'b0, dvs_q};
  assign resto_nuevo = cabe ? resta : resto_sh;
  assign despl_nuevo = {despl[N-2:0], cabe};

  always_comb begin
    estado_sig = estado;
    ready      = 1'b0;
    done       = 1'b0;
    case (estado)
      IDLE: begin
        ready = !pendiente;
        if (pendiente) begin
          if (exc_cero || exc_desb) estado_sig = DONE;
          else                      estado_sig = DIVIDE;
        end
      end
      DIVIDE: begin
        if (cnt == CW'(N - 1)) estado_sig = DONE;
      end
      DONE: begin
        done       = 1'b1;
        estado_sig = IDLE;
      end
      default: estado_sig = IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      estado    <= IDLE;
      dvd_q     <= '0;
      dvs_q     <= '0;
      pendiente <= 1'b0;
      resto     <= '0;
      despl     <= '0;
      cnt       <= '0;
      Cociente  <= '0;
      Residuo   <= '0;
      div_cero  <= 1'b0;
      desborde  <= 1'b0;
    end else begin
      estado <= estado_sig;
      case (estado)
        IDLE: begin
          if (pendiente) begin
            pendiente <= 1'b0;
            if (exc_cero) begin
              Cociente <= '1;
              Residuo  <= dvd_q[N-1:0];
              div_cero <= 1'b1;
            end else if (exc_desb) begin
              Cociente <= '1;
              Residuo  <= '0;
              desborde <= 1'b1;
            end else begin
              resto <= {1'b0, alto};
              despl <= dvd_q[N-1:0];
              cnt   <= '0;
            end
          end else if (start) begin
            dvd_q     <= Dividendo;
            dvs_q     <= Divisor;
            pendiente <= 1'b1;
            div_cero  <= 1'b0;
            desborde  <= 1'b0;
          end
        end
        DIVIDE: begin
          resto <= resto_nuevo;
          despl <= despl_nuevo;
          cnt   <= cnt + 1'b1;
          if (cnt == CW'(N - 1)) begin
            Cociente <= despl_nuevo;
            Residuo  <= resto_nuevo[N-1:0];
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_divisor_secuencial.sv
// tb/tb_divisor_secuencial.sv - directed and random checks of divisor_secuencial against an arithmetic model
module tb_divisor_secuencial;

  localparam int N = 24;

  logic           clk = 1'b0;
  logic           reset = 1'b1;
  logic           start = 1'b0;
  logic [2*N-1:0] Dividendo = '0;
  logic [N-1:0]   Divisor = '0;
  logic           ready, done, div_cero, desborde;
  logic [N-1:0]   Cociente, Residuo;

  int checks = 0;
  int failures = 0;

  divisor_secuencial #(.N(N)) dut (
    .clk(clk), .reset(reset), .start(start),
    .Dividendo(Dividendo), .Divisor(Divisor),
    .ready(ready), .done(done),
    .Cociente(Cociente), .Residuo(Residuo),
    .div_cero(div_cero), .desborde(desborde)
  );

  always #5 clk = ~clk;

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Plain integer division; exceptions decided from the arithmetic, not from the datapath
  task automatic model(input logic [2*N-1:0] dvd, input logic [N-1:0] dvs,
                       output logic [63:0] q, output logic [63:0] r,
                       output bit dz, output bit ov);
    logic [63:0] a, b;
    a = 64'(dvd);
    b = 64'(dvs);
    dz = 0; ov = 0;
    if (b == 0) begin
      dz = 1; q = (64'd1 << N) - 1; r = a & ((64'd1 << N) - 1);
    end else if (a / b >= (64'd1 << N)) begin
      ov = 1; q = (64'd1 << N) - 1; r = 0;
    end else begin
      q = a / b; r = a % b;
    end
  endtask

  task automatic run_div(input logic [2*N-1:0] dvd, input logic [N-1:0] dvs,
                         input bit meddle, input string tag);
    logic [63:0] eq, er;
    bit edz, eov, seen;
    int n;
    model(dvd, dvs, eq, er, edz, eov);
    @(negedge clk);
    chk({tag, "_ready"}, 64'(ready), 64'd1);
    Dividendo = dvd; Divisor = dvs; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    Dividendo = {$urandom, $urandom};
    Divisor = N'($urandom);
    n = 0; seen = 0;
    while (!seen && n < 100) begin
      if (done) seen = 1;
      else begin
        if (meddle && n == 4) begin
          start = 1'b1; Dividendo = 50; Divisor = 5;
        end else start = 1'b0;
        @(negedge clk);
        n++;
      end
    end
    start = 1'b0;
    chk({tag, "_done_seen"}, 64'(seen), 64'd1);
    chk({tag, "_latency"}, 64'(n), (edz || eov) ? 64'd1 : 64'(N + 1));
    chk({tag, "_ready_in_done"}, 64'(ready), 64'd0);
    chk({tag, "_q"}, 64'(Cociente), eq);
    chk({tag, "_r"}, 64'(Residuo), er);
    chk({tag, "_div_cero"}, 64'(div_cero), 64'(edz));
    chk({tag, "_desborde"}, 64'(desborde), 64'(eov));
    @(negedge clk);
    chk({tag, "_done_pulse"}, 64'(done), 64'd0);
    chk({tag, "_ready_after"}, 64'(ready), 64'd1);
    chk({tag, "_q_hold"}, 64'(Cociente), eq);
    chk({tag, "_r_hold"}, 64'(Residuo), er);
  endtask

  initial begin
    logic [N-1:0] dvs, hi, lo;
    bit any_done;
    int sel;

    // Reset state
    repeat (2) @(posedge clk);
    @(negedge clk);
    chk("rst_q", 64'(Cociente), 64'd0);
    chk("rst_r", 64'(Residuo), 64'd0);
    chk("rst_done", 64'(done), 64'd0);
    chk("rst_flags", {62'd0, div_cero, desborde}, 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("rst_ready", 64'(ready), 64'd1);

    // Directed cases
    run_div(48'd100, 24'd7, 0, "d100_7");
    run_div(48'hFFFFFE000001, 24'hFFFFFF, 0, "max_inverse");
    run_div(48'h000000001234, 24'd0, 0, "div_zero");
    run_div(48'h000001000000, 24'd1, 0, "overflow");
    run_div(48'd100, 24'd7, 1, "ignore_start");
    run_div(48'd50, 24'd5, 0, "after_ignore");
    run_div(48'h000000FFFFFF, 24'hFFFFFF, 0, "hi0_eq_lo");

    // Reset in the middle of a division
    @(negedge clk);
    Dividendo = 48'd100000; Divisor = 24'd7; start = 1'b1;
    @(posedge clk);
    @(negedge clk);
    start = 1'b0;
    repeat (11) @(negedge clk);
    reset = 1'b1;
    @(negedge clk);
    chk("abort_q", 64'(Cociente), 64'd0);
    chk("abort_r", 64'(Residuo), 64'd0);
    chk("abort_flags", {62'd0, div_cero, desborde}, 64'd0);
    chk("abort_done", 64'(done), 64'd0);
    reset = 1'b0;
    @(negedge clk);
    chk("abort_ready", 64'(ready), 64'd1);
    any_done = 0;
    repeat (40) begin
      @(negedge clk);
      if (done) any_done = 1;
    end
    chk("abort_no_done", 64'(any_done), 64'd0);
    run_div(48'd1000, 24'd3, 0, "d1000_3");

    // Random operands: mostly normal, some zero divisors and overflows
    for (int i = 0; i < 30; i++) begin
      sel = $urandom_range(0, 9);
      dvs = N'($urandom);
      lo  = N'($urandom);
      if (sel == 0) begin
        dvs = '0;
        hi  = N'($urandom);
      end else if (sel == 1) begin
        if (dvs == '0) dvs = 1;
        hi = dvs + N'($urandom_range(0, (1 << N) - 1 - int'(dvs)));
      end else begin
        if (dvs == '0) dvs = 1;
        hi = N'($urandom % int'(dvs));
      end
      run_div({hi, lo}, dvs, (sel == 5), $sformatf("rand%0d", i));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
